// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
package seq_det_pkg;

    // Reset defaults, matching the legacy fixed "1010" detector.
    localparam int unsigned DEF_MAX_LEN     = 8;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam logic [31:0] DEF_RST_PATTERN = 32'h0000_000A;
    localparam int unsigned DEF_RST_LEN     = 4;
    localparam bit          DEF_RST_OVERLAP = 1'b0;

    // Width needed to hold a length in the range 0..max_len.
    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len) + 1;
    endfunction

    // A zero length would never complete a match, so it is treated as 1.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coincident with an
// increment leaves the count at 1.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = inc_i ? CNT_W'(1) : '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with programmable pattern/length, optional
// overlapping matches, a data-valid qualifier and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN     = DEF_MAX_LEN,
    parameter int unsigned        CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
    parameter int unsigned        RST_LEN     = DEF_RST_LEN,
    parameter bit                 RST_OVERLAP = DEF_RST_OVERLAP,
    localparam int unsigned       LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               data_valid,
    input  logic               data,
    output logic               tick,
    output logic [CNT_W-1:0]   match_count,
    input  logic               cnt_clr,
    output logic               busy
);

    localparam logic [LEN_W-1:0] RstLenClamped = LEN_W'(clamp_len(RST_LEN, MAX_LEN));
    localparam logic [LEN_W-1:0] MaxFill       = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               tick_q;
    logic               busy_q;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic               window_eq;
    logic               match;

    // Sliding-window compare on the post-shift history plus next-state selection.
    always_comb begin
        pat_d      = pat_q;
        len_d      = len_q;
        ovl_d      = ovl_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        match      = 1'b0;
        hist_shift = {hist_q[MAX_LEN-2:0], data};
        fill_inc   = (fill_q >= MaxFill) ? fill_q : fill_q + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        window_eq = (((hist_shift ^ pat_q) & len_mask) == '0);

        if (cfg_load) begin
            // A data bit in the same cycle is dropped; detection restarts clean.
            pat_d  = cfg_pattern;
            len_d  = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (data_valid) begin
            hist_d = hist_shift;
            match  = (fill_inc >= len_q) && window_eq;
            // Non-overlap mode consumes the matched bits.
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
        end
    end

    // Configuration, history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q  <= RST_PATTERN;
            len_q  <= RstLenClamped;
            ovl_q  <= RST_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            tick_q <= match;
            busy_q <= (fill_d != '0);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .inc_i   (match),
        .count_o (match_count)
    );

    assign tick = tick_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       data_valid = 1'b0;
    logic       data = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       tick, tick2, busy, busy2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .data_valid  (data_valid),
        .data        (data),
        .tick        (tick),
        .match_count (match_count),
        .cnt_clr     (cnt_clr),
        .busy        (busy)
    );

    seq_detector_param #(
        .CNT_W (2)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .data_valid  (data_valid),
        .data        (data),
        .tick        (tick2),
        .match_count (match_count2),
        .cnt_clr     (cnt_clr),
        .busy        (busy2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic exp_tick, input string tag);
        data_valid = 1'b1;
        data       = b;
        step();
        data_valid = 1'b0;
        check_eq(tag, {31'd0, tick}, {31'd0, exp_tick});
    endtask

    // Send n bits MSB first; ticks[k] is the expected tick after bits[k].
    task automatic send_seq(input logic [7:0] bits, input int n, input logic [7:0] ticks,
                            input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], ticks[i], $sformatf("%s_tick[%0d]", tag, n - 1 - i));
        end
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic clr, input string tag);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cnt_clr     = clr;
        step();
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_counts(input string tag, input int exp8, input int exp2);
        check_eq({tag, "_cnt8"}, {24'd0, match_count}, exp8);
        check_eq({tag, "_cnt2"}, {30'd0, match_count2}, exp2);
    endtask

    initial begin
        int gaps [8] = '{0, 1, 2, 3, 0, 2, 1, 0};
        logic [7:0] pat8;

        // Reset state
        #2;
        check_eq("rst_tick", {31'd0, tick}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_counts("rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Default config 1010 len 4
        send_seq(8'b0000_1010, 4, 8'b0000_0001, "t1");
        check_eq("t1_busy", {31'd0, busy}, 32'd0);
        check_counts("t1", 1, 1);
        data_valid = 1'b0;
        step();
        check_eq("t1_tick_drop", {31'd0, tick}, 32'd0);

        // Non-overlap: 10101010 -> ticks after bits 4 and 8
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check_counts("t2_clr", 0, 0);
        send_seq(8'b1010_1010, 8, 8'b0001_0001, "t2");
        check_counts("t2", 2, 2);

        // Overlap: ticks after bits 4, 6, 8
        do_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b1, "t3_cfg");
        send_seq(8'b1010_1010, 8, 8'b0001_0101, "t3");
        check_counts("t3", 3, 3);

        // Length 8 pattern with valid gaps
        do_cfg(8'b1101_1000, 4'd8, 1'b0, 1'b1, "t4_cfg");
        pat8 = 8'b1101_1000;
        for (int i = 0; i < 8; i++) begin
            send(pat8[7-i], (i == 7), $sformatf("t4_tick[%0d]", i));
            check_eq($sformatf("t4_busy[%0d]", i), {31'd0, busy}, (i < 7) ? 32'd1 : 32'd0);
            for (int g = 0; g < gaps[i]; g++) begin
                step();
                check_eq($sformatf("t4_gap_tick[%0d]", i), {31'd0, tick}, 32'd0);
            end
        end
        check_counts("t4", 1, 1);

        // Sliding window: 11010 matches at bit 5
        do_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b0, "t5_cfg");
        send_seq(8'b0001_1010, 5, 8'b0000_0001, "t5");
        check_counts("t5", 2, 2);

        // len 0 clamps to 1, pattern bit 0 = 1
        do_cfg(8'b0000_0001, 4'd0, 1'b0, 1'b0, "t6_cfg");
        send_seq(8'b0001_0110, 5, 8'b0001_0110, "t6");
        check_counts("t6", 5, 3);

        // len 15 clamps to 8
        do_cfg(8'b1101_1000, 4'd15, 1'b0, 1'b0, "t7_cfg");
        send_seq(8'b1101_1000, 8, 8'b0000_0001, "t7");
        check_counts("t7", 6, 3);

        // Saturation of the 2-bit counter
        do_cfg(8'b0000_0001, 4'd1, 1'b0, 1'b1, "t8_cfg");
        check_counts("t8_clr", 0, 0);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b1, $sformatf("t8_tick[%0d]", i));
            check_counts($sformatf("t8[%0d]", i), i + 1, (i < 3) ? i + 1 : 3);
        end

        // Clear coincident with a match
        cnt_clr = 1'b1;
        send(1'b1, 1'b1, "t9_tick");
        cnt_clr = 1'b0;
        check_counts("t9", 1, 1);

        // cfg_load wins over the completing data bit
        do_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b0, "t10_cfg");
        send_seq(8'b0000_0101, 3, 8'b0000_0000, "t10");
        check_eq("t10_busy_pre", {31'd0, busy}, 32'd1);
        cfg_load   = 1'b1;
        data_valid = 1'b1;
        data       = 1'b0;
        step();
        cfg_load   = 1'b0;
        data_valid = 1'b0;
        check_eq("t10_tick", {31'd0, tick}, 32'd0);
        check_eq("t10_busy", {31'd0, busy}, 32'd0);
        check_counts("t10", 1, 1);

        // Reset mid-stream aborts the partial match
        send_seq(8'b0000_0101, 3, 8'b0000_0000, "t11_pre");
        reset = 1'b1;
        #2;
        check_eq("t11_busy_rst", {31'd0, busy}, 32'd0);
        check_counts("t11_rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        send(1'b0, 1'b0, "t11_last_bit");
        send_seq(8'b0000_1010, 4, 8'b0000_0001, "t11");
        check_counts("t11", 1, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
